// File: rtl/attn_pkg.sv
// Shared widths and FSM state type for the attention-score generator.
package attn_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DOT  = 3'd1,
    EXP  = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } attn_sg_state_t;

  function automatic int dot_w(input int dw, input int head_dim);
    return 2 * dw + $clog2(head_dim);
  endfunction

  function automatic int wgt_w(input int frac_w);
    return frac_w + 1;
  endfunction

  function automatic int sum_w(input int frac_w, input int seq_len);
    return frac_w + 1 + $clog2(seq_len);
  endfunction

  // Widths at the default configuration (DW=4, HEAD_DIM=2, FRAC_W=4, SEQ_LEN=3).
  localparam int DOT_W = dot_w(4, 2);
  localparam int WGT_W = wgt_w(4);
  localparam int SUM_W = sum_w(4, 3);

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The caller guarantees num / den < 2**QW, so only the low QW numerator bits need stepping.
module seq_divider #(
  parameter int NW = 9,
  parameter int DENW = 7,
  parameter int QW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [NW-1:0]   num,
  input  logic [DENW-1:0] den,
  output logic            busy,
  output logic            done,
  output logic [QW-1:0]   quotient
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  logic [DENW-1:0] rem;
  logic [DENW-1:0] den_q;
  logic [QW-1:0]   nbits;
  logic [QW-1:0]   quo;
  logic [CW-1:0]   cnt;
  logic [DENW:0]   trial;
  logic            ge;

  always_comb begin
    trial = {rem, nbits[QW-1]};
    ge    = (trial >= {1'b0, den_q});
  end

  // done and quotient are valid during the final step, so the caller can
  // capture the result on the same edge that retires the division.
  assign done     = busy && (cnt == CW'(QW - 1));
  assign quotient = {quo[QW-2:0], ge};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem   <= '0;
      den_q <= '0;
      nbits <= '0;
      quo   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      rem   <= DENW'(num >> QW);
      den_q <= den;
      nbits <= num[QW-1:0];
      quo   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      rem   <= ge ? DENW'(trial - {1'b0, den_q}) : DENW'(trial);
      nbits <= nbits << 1;
      quo   <= quotient;
      cnt   <= cnt + CW'(1);
      if (cnt == CW'(QW - 1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/attn_score_gen.sv
// Attention score generator: q.k_i dot products, base-2 exp with max subtraction,
// then per-element normalization to unsigned Q0.FRAC_W through a shared divider.
module attn_score_gen
  import attn_pkg::*;
#(
  parameter int SEQ_LEN  = 3,
  parameter int HEAD_DIM = 2,
  parameter int DW       = 4,
  parameter int FRAC_W   = 4,
  parameter int TEMP_SH  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DW-1:0]     q     [0:HEAD_DIM-1],
  input  logic signed [DW-1:0]     k_mat [0:SEQ_LEN-1][0:HEAD_DIM-1],
  output logic                     busy,
  output logic                     out_valid,
  output logic        [FRAC_W-1:0] score [0:SEQ_LEN-1],
  output attn_sg_state_t           dbg_state
);

  localparam int DOT_BITS = dot_w(DW, HEAD_DIM);
  localparam int WGT_BITS = wgt_w(FRAC_W);
  localparam int SUM_BITS = sum_w(FRAC_W, SEQ_LEN);
  localparam int NUM_BITS = WGT_BITS + FRAC_W;
  localparam int IW       = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);

  attn_sg_state_t state, state_nxt;

  logic        [IW-1:0]       idx;
  logic signed [DOT_BITS-1:0] raw [0:SEQ_LEN-1];
  logic        [WGT_BITS-1:0] wgt [0:SEQ_LEN-1];
  logic signed [DOT_BITS-1:0] max_q;
  logic        [SUM_BITS-1:0] sum_q;

  logic signed [DOT_BITS-1:0] dot;
  logic signed [2*DW-1:0]     prod;
  logic signed [DOT_BITS:0]   diff;
  logic        [DOT_BITS:0]   d_u;
  logic        [WGT_BITS-1:0] one_w;
  logic        [WGT_BITS-1:0] w_cur;

  logic                div_load, div_busy, div_done;
  logic [FRAC_W:0]     div_quo;
  logic [FRAC_W-1:0]   score_sat;

  // start is a request accepted only in IDLE; out_valid is a one-cycle completion
  // pulse with no back-pressure, and score[] stays stable until the next accepted start.
  assign busy      = (state != IDLE) && (state != DONE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    dot  = '0;
    prod = '0;
    for (int h = 0; h < HEAD_DIM; h++) begin
      prod = q[h] * k_mat[idx][h];
      dot  = dot + DOT_BITS'(prod);
    end
  end

  // d is non-negative because max_q bounds every raw entry.
  always_comb begin
    diff  = {max_q[DOT_BITS-1], max_q} - {raw[idx][DOT_BITS-1], raw[idx]};
    d_u   = $unsigned(diff >>> TEMP_SH);
    one_w = WGT_BITS'(1) << FRAC_W;
    w_cur = (d_u > (DOT_BITS + 1)'(FRAC_W)) ? '0 : (one_w >> d_u);
  end

  assign score_sat = div_quo[FRAC_W] ? '1 : div_quo[FRAC_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_load  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = DOT;
      DOT:  if (idx == LAST) state_nxt = EXP;
      EXP:  if (idx == LAST) state_nxt = NORM;
      NORM: begin
        div_load = !div_busy;
        if (div_done && idx == LAST) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      max_q <= '0;
      sum_q <= '0;
      for (int i = 0; i < SEQ_LEN; i++) begin
        raw[i]   <= '0;
        wgt[i]   <= '0;
        score[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            sum_q <= '0;
          end
        end
        DOT: begin
          raw[idx] <= dot;
          if (idx == '0 || dot > max_q) max_q <= dot;
          idx <= (idx == LAST) ? '0 : idx + IW'(1);
        end
        EXP: begin
          wgt[idx] <= w_cur;
          sum_q    <= sum_q + SUM_BITS'(w_cur);
          idx      <= (idx == LAST) ? '0 : idx + IW'(1);
        end
        NORM: begin
          if (div_done) begin
            score[idx] <= score_sat;
            idx        <= (idx == LAST) ? '0 : idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  seq_divider #(
    .NW  (NUM_BITS),
    .DENW(SUM_BITS),
    .QW  (FRAC_W + 1)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (div_load),
    .num     ({wgt[idx], {FRAC_W{1'b0}}}),
    .den     (sum_q),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

endmodule

// File: tb/tb_attn_score_gen.sv
// Directed bench for attn_score_gen: default instance plus a TEMP_SH=1 instance.
module tb_attn_score_gen;
  import attn_pkg::*;

  localparam int SEQ_LEN = 3;
  localparam int HEAD_DIM = 2;
  localparam int DW = 4;
  localparam int FRAC_W = 4;
  localparam int EXP_LAT = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_t = 1'b0;
  logic signed [DW-1:0] q [0:HEAD_DIM-1];
  logic signed [DW-1:0] k_mat [0:SEQ_LEN-1][0:HEAD_DIM-1];

  logic busy, out_valid, busy_t, out_valid_t;
  logic [FRAC_W-1:0] score [0:SEQ_LEN-1];
  logic [FRAC_W-1:0] score_t [0:SEQ_LEN-1];
  attn_sg_state_t dbg_state, dbg_state_t;

  logic [FRAC_W-1:0] exp_q[$];
  logic [FRAC_W-1:0] e;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  attn_score_gen #(.TEMP_SH(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q(q), .k_mat(k_mat),
    .busy(busy), .out_valid(out_valid), .score(score), .dbg_state(dbg_state)
  );

  attn_score_gen #(.TEMP_SH(1)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start_t), .q(q), .k_mat(k_mat),
    .busy(busy_t), .out_valid(out_valid_t), .score(score_t), .dbg_state(dbg_state_t)
  );

  task automatic set_vec(input int q0, input int q1, input int k00, input int k01,
                         input int k10, input int k11, input int k20, input int k21);
    q[0] = DW'(q0);  q[1] = DW'(q1);
    k_mat[0][0] = DW'(k00); k_mat[0][1] = DW'(k01);
    k_mat[1][0] = DW'(k10); k_mat[1][1] = DW'(k11);
    k_mat[2][0] = DW'(k20); k_mat[2][1] = DW'(k21);
  endtask

  // Pulses start on the chosen instance and waits (bounded) for out_valid.
  // lat counts cycles after the accepting edge; busy_cyc counts sampled busy cycles.
  task automatic run_op(input bit use_t, output int lat, output int busy_cyc);
    logic bsy, ov;
    lat = 0;
    busy_cyc = 0;
    @(negedge clk);
    if (use_t) start_t = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_t = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bsy = use_t ? busy_t : busy;
      ov  = use_t ? out_valid_t : out_valid;
      if (bsy) busy_cyc++;
      if (ov) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      total++; if (score[i] !== '0) begin bad++; $display("FAIL reset_score[%0d] got=%0d exp=0", i, score[i]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    set_vec(1, 0, 2, 0, 1, 0, 0, 0);
    exp_q.push_back(4'd9); exp_q.push_back(4'd4); exp_q.push_back(4'd2);
    run_op(1'b0, lat, bc);
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, EXP_LAT); end
    total++; if (bc != EXP_LAT - 1) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, EXP_LAT - 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_valid got=%b exp=0", busy); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      e = exp_q.pop_front();
      total++; if (score[i] !== e) begin bad++; $display("FAIL basic_score[%0d] got=%0d exp=%0d", i, score[i], e); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL basic_pulse_end got ov=%b st=%0d exp ov=0 st=%0d", out_valid, dbg_state, IDLE);
    end
  endtask

  task automatic test_zero_query();
    int lat, bc;
    set_vec(0, 0, 3, -2, -5, 7, 1, 4);
    repeat (3) exp_q.push_back(4'd5);
    run_op(1'b0, lat, bc);
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL zero_latency got=%0d exp=%0d", lat, EXP_LAT); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      e = exp_q.pop_front();
      total++; if (score[i] !== e) begin bad++; $display("FAIL zero_score[%0d] got=%0d exp=%0d", i, score[i], e); end
    end
  endtask

  task automatic test_saturation();
    int lat, bc;
    set_vec(7, 7, 7, 7, -8, -8, 0, 0);
    exp_q.push_back(4'd15); exp_q.push_back(4'd0); exp_q.push_back(4'd0);
    run_op(1'b0, lat, bc);
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL sat_latency got=%0d exp=%0d", lat, EXP_LAT); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      e = exp_q.pop_front();
      total++; if (score[i] !== e) begin bad++; $display("FAIL sat_score[%0d] got=%0d exp=%0d", i, score[i], e); end
    end
  endtask

  task automatic test_temperature();
    int lat, bc;
    set_vec(1, 0, 2, 0, 1, 0, 0, 0);
    exp_q.push_back(4'd6); exp_q.push_back(4'd6); exp_q.push_back(4'd3);
    run_op(1'b1, lat, bc);
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL temp_latency got=%0d exp=%0d", lat, EXP_LAT); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      e = exp_q.pop_front();
      total++; if (score_t[i] !== e) begin bad++; $display("FAIL temp_score[%0d] got=%0d exp=%0d", i, score_t[i], e); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    set_vec(1, 0, 2, 0, 1, 0, 0, 0);
    run_op(1'b0, lat, bc);
    set_vec(0, 0, 1, 1, 2, 2, 3, 3);
    repeat (3) exp_q.push_back(4'd5);
    run_op(1'b0, lat, bc);
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, EXP_LAT); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      e = exp_q.pop_front();
      total++; if (score[i] !== e) begin bad++; $display("FAIL b2b_score[%0d] got=%0d exp=%0d", i, score[i], e); end
    end
  endtask

  task automatic test_ignored_start();
    int ov_cnt, ov_at;
    ov_cnt = 0;
    ov_at = 0;
    set_vec(1, 0, 2, 0, 1, 0, 0, 0);
    exp_q.push_back(4'd9); exp_q.push_back(4'd4); exp_q.push_back(4'd2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ov_cnt++;
        if (ov_at == 0) ov_at = c;
      end
      start = (c == 10 || c == 25);
    end
    start = 1'b0;
    total++; if (ov_cnt != 1) begin bad++; $display("FAIL ignore_pulse_count got=%0d exp=1", ov_cnt); end
    total++; if (ov_at != EXP_LAT) begin bad++; $display("FAIL ignore_latency got=%0d exp=%0d", ov_at, EXP_LAT); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy_after got=%b exp=0", busy); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      e = exp_q.pop_front();
      total++; if (score[i] !== e) begin bad++; $display("FAIL ignore_score[%0d] got=%0d exp=%0d", i, score[i], e); end
    end
  endtask

  task automatic test_reset_mid_norm();
    int lat, bc, stale;
    stale = 0;
    set_vec(1, 0, 2, 0, 1, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstnorm_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstnorm_out_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      total++; if (score[i] !== '0) begin bad++; $display("FAIL rstnorm_score[%0d] got=%0d exp=0", i, score[i]); end
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rstnorm_stale_valid got=%0d exp=0", stale); end
    exp_q.push_back(4'd9); exp_q.push_back(4'd4); exp_q.push_back(4'd2);
    run_op(1'b0, lat, bc);
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL rstnorm_latency got=%0d exp=%0d", lat, EXP_LAT); end
    for (int i = 0; i < SEQ_LEN; i++) begin
      e = exp_q.pop_front();
      total++; if (score[i] !== e) begin bad++; $display("FAIL rstnorm_score2[%0d] got=%0d exp=%0d", i, score[i], e); end
    end
  endtask

  initial begin
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_zero_query();
    test_saturation();
    test_temperature();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_norm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
